// File: rtl/control_bus_rtc.sv
// Master for the RTC multiplexed address/data bus: one address phase per byte, bursts with an
// auto-incrementing address, write-data pull strobe, read capture and abort.
module control_bus_rtc #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int T_AS   = 6,
    parameter int T_GAP  = 12,
    parameter int T_DS   = 6,
    parameter int T_REC  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              escribe,
    input  logic [DATA_W-1:0] direccion,
    input  logic [LEN_W-1:0]  longitud,
    input  logic              abortar,
    input  logic [DATA_W-1:0] dato,
    output logic              dato_tomado,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              CS,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] leido,
    output logic              leido_valido,
    output logic              ocupado,
    output logic              finalizado,
    output logic              abortado
);
    localparam int T_M1  = (T_AS > T_GAP) ? T_AS : T_GAP;
    localparam int T_M2  = (T_DS > T_REC) ? T_DS : T_REC;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int CNT_W = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, REC, DONE} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    ph_cnt, ph_n;
    logic [DATA_W-1:0]   addr, addr_n;
    logic [LEN_W-1:0]    byte_cnt, byte_n, len, len_n;
    logic                wr_mode, mode_n;
    logic                last_ph, abort_now, take, capture;
    logic                cs_n, ad_n, rd_n, wr_n, oe_n;

    // Counter holds cycles remaining minus one in the current phase.
    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            ADDR:    phase_len = CNT_W'(T_AS - 1);
            GAP:     phase_len = CNT_W'(T_GAP - 1);
            DATA:    phase_len = CNT_W'(T_DS - 1);
            REC:     phase_len = CNT_W'(T_REC - 1);
            default: phase_len = '0;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        byte_n    = byte_cnt;
        len_n     = len;
        mode_n    = wr_mode;
        last_ph   = (ph_cnt == '0);
        abort_now = abortar && (state != IDLE) && (state != DONE);
        case (state)
            IDLE: if (iniciar) begin
                state_n = ADDR;
                addr_n  = direccion;
                byte_n  = '0;
                len_n   = longitud;
                mode_n  = escribe;
            end
            ADDR: if (last_ph) state_n = GAP;
            GAP:  if (last_ph) state_n = DATA;
            DATA: if (last_ph) state_n = REC;
            REC:  if (last_ph) begin
                if (byte_cnt == len) begin
                    state_n = DONE;
                end else begin
                    state_n = ADDR;
                    addr_n  = addr + DATA_W'(1);
                    byte_n  = byte_cnt + LEN_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort overrides every transition, including the read capture edge.
        if (abort_now) begin
            state_n = IDLE;
            addr_n  = addr;
            byte_n  = byte_cnt;
        end
        if (state_n != state)
            ph_n = phase_len(state_n);
        else
            ph_n = last_ph ? ph_cnt : ph_cnt - CNT_W'(1);

        take    = (state == ADDR) && (state_n == GAP) && wr_mode;
        capture = (state == DATA) && (state_n == REC) && !wr_mode;
        // Outputs are decoded from the state being entered so they register with it.
        cs_n = !((state_n == ADDR) || (state_n == DATA));
        ad_n = !(state_n == ADDR);
        wr_n = !((state_n == ADDR) || ((state_n == DATA) && mode_n));
        rd_n = !((state_n == DATA) && !mode_n);
        oe_n = (state_n == ADDR) || (mode_n && ((state_n == GAP) || (state_n == DATA)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            addr         <= '0;
            byte_cnt     <= '0;
            len          <= '0;
            wr_mode      <= 1'b0;
            CS           <= 1'b1;
            AD           <= 1'b1;
            RD           <= 1'b1;
            WR           <= 1'b1;
            bus_oe       <= 1'b0;
            bus_out      <= '0;
            leido        <= '0;
            dato_tomado  <= 1'b0;
            leido_valido <= 1'b0;
            ocupado      <= 1'b0;
            finalizado   <= 1'b0;
            abortado     <= 1'b0;
        end else begin
            state        <= state_n;
            ph_cnt       <= ph_n;
            addr         <= addr_n;
            byte_cnt     <= byte_n;
            len          <= len_n;
            wr_mode      <= mode_n;
            CS           <= cs_n;
            AD           <= ad_n;
            RD           <= rd_n;
            WR           <= wr_n;
            bus_oe       <= oe_n;
            if (state_n == ADDR)
                bus_out <= addr_n;
            else if (take)
                bus_out <= dato;
            if (capture)
                leido <= bus_in;
            dato_tomado  <= take;
            leido_valido <= capture;
            ocupado      <= (state_n != IDLE);
            finalizado   <= (state_n == DONE);
            abortado     <= abort_now;
        end
    end
endmodule

// File: tb/tb_control_bus_rtc.sv
// Randomized scoreboard bench for control_bus_rtc: expected bus events are planned from the
// per-byte timing arithmetic and popped by a monitor as the DUT produces them.
module tb_control_bus_rtc;
    localparam int T_AS = 6, T_GAP = 12, T_DS = 6, T_REC = 2;
    localparam int P = T_AS + T_GAP + T_DS + T_REC;
    localparam int K_ADDR = 0, K_TOM = 1, K_WD = 2, K_RD = 3, K_FIN = 4, K_ABT = 5;
    localparam int BIG = 1 << 20;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar, escribe, abortar;
    logic [7:0] direccion, dato, bus_in, bus_out, leido;
    logic [3:0] longitud;
    logic       dato_tomado, bus_oe, CS, AD, RD, WR, leido_valido, ocupado, finalizado, abortado;

    logic       f_iniciar, f_escribe, f_abortar;
    logic [7:0] f_direccion, f_dato, f_bus_in, f_bus_out, f_leido;
    logic [3:0] f_longitud;
    logic       f_dato_tomado, f_bus_oe, f_CS, f_AD, f_RD, f_WR, f_leido_valido, f_ocupado, f_finalizado, f_abortado;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    ev_t        exp_q[$];
    logic [7:0] wq[$];
    logic [7:0] mem [256];
    logic [7:0] lat = 8'h00;
    logic [7:0] exp_leido = 8'h00;

    control_bus_rtc dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .escribe(escribe), .direccion(direccion),
        .longitud(longitud), .abortar(abortar), .dato(dato), .dato_tomado(dato_tomado),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .CS(CS), .AD(AD), .RD(RD), .WR(WR),
        .leido(leido), .leido_valido(leido_valido), .ocupado(ocupado), .finalizado(finalizado),
        .abortado(abortado)
    );

    control_bus_rtc #(.T_AS(1), .T_GAP(1), .T_DS(1), .T_REC(1)) dut_fast (
        .clk(clk), .reset(reset), .iniciar(f_iniciar), .escribe(f_escribe), .direccion(f_direccion),
        .longitud(f_longitud), .abortar(f_abortar), .dato(f_dato), .dato_tomado(f_dato_tomado),
        .bus_in(f_bus_in), .bus_out(f_bus_out), .bus_oe(f_bus_oe), .CS(f_CS), .AD(f_AD), .RD(f_RD),
        .WR(f_WR), .leido(f_leido), .leido_valido(f_leido_valido), .ocupado(f_ocupado),
        .finalizado(f_finalizado), .abortado(f_abortado)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC side: latch the address, return the register contents while RD is low.
    always @(negedge clk) if (!CS && !AD) lat = bus_out;
    assign bus_in = RD ? 8'h00 : mem[lat];

    function automatic string kname(input int k);
        case (k)
            K_ADDR:  return "addr";
            K_TOM:   return "dato_tomado";
            K_WD:    return "wdata";
            K_RD:    return "leido";
            K_FIN:   return "final";
            default: return "abortado";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input logic [7:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got unexpected %s val=%0h at cycle %0d, expected none", kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s val=%0h cyc=%0d expected %s val=%0h cyc=%0d",
                         kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: bus protocol sanity every cycle plus event extraction for the scoreboard.
    initial begin
        logic prev_ad, prev_wd, wd;
        prev_ad = 1'b1;
        prev_wd = 1'b0;
        forever begin
            @(negedge clk);
            wd = !CS && AD && !WR;
            checks++;
            if ((!RD && !WR) || (!AD && CS) || (!RD && bus_oe) || (!CS && !ocupado)) begin
                errors++;
                $display("FAIL strobes: CS=%b AD=%b RD=%b WR=%b oe=%b ocupado=%b at cycle %0d, expected a legal combination",
                         CS, AD, RD, WR, bus_oe, ocupado, cyc);
            end
            if (!AD && prev_ad) see(K_ADDR, bus_out);
            if (dato_tomado)    see(K_TOM, 8'h00);
            if (wd && !prev_wd) see(K_WD, bus_out);
            if (leido_valido)   see(K_RD, leido);
            if (finalizado)     see(K_FIN, 8'h00);
            if (abortado)       see(K_ABT, 8'h00);
            prev_ad = AD;
            prev_wd = wd;
        end
    end

    // Write-data source: present the head byte, advance on each pull strobe.
    initial begin
        dato = 8'h00;
        forever begin
            @(negedge clk);
            if (dato_tomado && wq.size() > 0) wq.delete(0);
            dato = (wq.size() > 0) ? wq[0] : 8'hA5;
        end
    end

    // Reference: byte i starts at relative cycle i*P+1; events later than 'cut' never happen.
    task automatic plan(input bit wr, input logic [7:0] dir, input int len, input logic [7:0] first,
                        input int base, input int cut);
        logic [7:0] a, d;
        int b;
        for (int i = 0; i <= len; i++) begin
            b = i * P;
            a = dir + 8'(i);
            d = (i == 0) ? first : 8'($urandom);
            if (wr) wq.push_back(d);
            if (b + 1 <= cut) expect_ev(K_ADDR, a, base + b + 1);
            if (wr) begin
                if (b + T_AS + 1 <= cut) expect_ev(K_TOM, 8'h00, base + b + T_AS + 1);
                if (b + T_AS + T_GAP + 1 <= cut) expect_ev(K_WD, d, base + b + T_AS + T_GAP + 1);
            end else if (b + T_AS + T_GAP + T_DS + 1 <= cut) begin
                expect_ev(K_RD, mem[a], base + b + T_AS + T_GAP + T_DS + 1);
                exp_leido = mem[a];
            end
        end
        if ((len + 1) * P + 1 <= cut) expect_ev(K_FIN, 8'h00, base + (len + 1) * P + 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // kind: 0 plain, 1 abortar in cycle j, 2 reset in cycle j, 3 stray iniciar pulse in cycle j
    task automatic run_txn(input bit wr, input logic [7:0] dir, input int len, input logic [7:0] first,
                           input int kind, input int j);
        int base, tot, cut;
        tot = (len + 1) * P + 1;
        cut = BIG;
        if (kind == 1 && j < tot) cut = j;
        if (kind == 2) cut = j - 1;
        @(posedge clk); #1;
        base = cyc;
        plan(wr, dir, len, first, base, cut);
        if (kind == 1 && j < tot) expect_ev(K_ABT, 8'h00, base + j + 1);
        escribe = wr; direccion = dir; longitud = 4'(len); iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0; escribe = !wr; direccion = ~dir; longitud = 4'($urandom);
        if (kind != 0) begin
            while (cyc < base + j) begin @(posedge clk); #1; end
            case (kind)
                1: begin
                    abortar = 1'b1;
                    @(posedge clk); #1;
                    abortar = 1'b0;
                    if (j < tot) chk("abort outputs", {CS, AD, RD, WR, bus_oe, abortado}, 6'b111101);
                end
                2: begin
                    reset = 1'b0;
                    #1;
                    chk("async reset outputs", {CS, AD, RD, WR, bus_oe, ocupado}, 6'b111100);
                    exp_leido = 8'h00;
                    repeat (2) @(posedge clk);
                    #1 reset = 1'b1;
                    @(posedge clk); #1;
                    chk("idle after reset", {ocupado, CS}, 2'b01);
                end
                default: begin
                    iniciar = 1'b1;
                    @(posedge clk); #1;
                    iniciar = 1'b0;
                end
            endcase
        end
        drain();
        wq.delete();
        chk("leido", leido, exp_leido);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, tot, r, j;
        logic [7:0] d0, d1, dir;
        logic [6:0] ev;
        bit wr;
        iniciar = 0; escribe = 0; abortar = 0; direccion = 0; longitud = 0;
        f_iniciar = 0; f_escribe = 0; f_abortar = 0; f_direccion = 0; f_longitud = 0;
        f_dato = 0; f_bus_in = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
        mem[8'h20] = 8'h6B; mem[8'h21] = 8'h94;

        #1 reset = 1'b0;
        #1;
        chk("reset strobes", {CS, AD, RD, WR, bus_oe}, 5'b11110);
        chk("reset bus_out", bus_out, 8'h00);
        chk("reset leido", leido, 8'h00);
        chk("reset pulses", {dato_tomado, leido_valido, ocupado, finalizado, abortado}, 5'b00000);
        chk("reset fast strobes", {f_CS, f_AD, f_RD, f_WR, f_bus_oe, f_ocupado}, 6'b111100);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_txn(1'b1, 8'h0A, 0, 8'h5C, 0, 0);            // single write
        run_txn(1'b0, 8'hFE, 2, 8'h00, 0, 0);            // read burst across address wrap
        run_txn(1'b1, 8'h30, 1, 8'($urandom), 1, P + 10); // abort in GAP of byte 2
        run_txn(1'b1, 8'h31, 0, 8'($urandom), 0, 0);     // fresh start after abort
        run_txn(1'b0, 8'h12, 0, 8'h00, 3, 10);           // stray iniciar while busy

        // iniciar held high: second transaction starts right after the idle cycle following DONE
        @(posedge clk); #1;
        base = cyc;
        plan(1'b0, 8'h40, 0, 8'h00, base, BIG);
        plan(1'b0, 8'h80, 1, 8'h00, base + P + 2, BIG);
        escribe = 0; direccion = 8'h40; longitud = 0; iniciar = 1;
        @(posedge clk); #1;
        direccion = 8'h80; longitud = 4'd1;
        while (cyc < base + P + 2) begin @(posedge clk); #1; end
        chk("idle between held starts", ocupado, 1'b0);
        @(posedge clk); #1;
        iniciar = 0;
        drain();
        chk("leido after held starts", leido, exp_leido);

        run_txn(1'b1, 8'h50, 0, 8'($urandom), 2, T_AS + T_GAP + 3); // reset mid write DATA
        run_txn(1'b0, 8'h20, 0, 8'h00, 0, 0);
        run_txn(1'b0, 8'h21, 0, 8'h00, 1, T_AS + T_GAP + T_DS);     // abort on the capture edge
        run_txn(1'b1, 8'h60, 0, 8'($urandom), 1, P + 1);             // abort during DONE

        // abortar in IDLE together with a start has no effect
        @(posedge clk); #1;
        base = cyc;
        plan(1'b0, 8'h70, 0, 8'h00, base, BIG);
        escribe = 0; direccion = 8'h70; longitud = 0; iniciar = 1; abortar = 1;
        @(posedge clk); #1;
        iniciar = 0; abortar = 0;
        drain();
        chk("leido after idle abort", leido, exp_leido);

        for (int n = 0; n < 10; n++) begin
            wr = 1'($urandom);
            dir = 8'($urandom);
            r = $urandom_range(0, 3);
            tot = (r + 1) * P + 1;
            j = $urandom_range(1, tot);
            run_txn(wr, dir, r, 8'($urandom), ($urandom % 3 == 0) ? 1 : 0, j);
        end

        // Minimal phase widths: 4 cycles per byte, DONE at cycle 9
        d0 = 8'($urandom); d1 = 8'($urandom); dir = 8'($urandom);
        @(posedge clk); #1;
        f_escribe = 1; f_direccion = dir; f_longitud = 4'd1; f_dato = d0; f_iniciar = 1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) f_iniciar = 0;
            if (c <= 8) begin
                r = (c - 1) % 4;
                ev = {(r == 1 || r == 3), (r != 0), 1'b1, (r == 1 || r == 3), 1'b0, 1'b1, (r == 1)};
                if (r == 0) chk("fast addr bus", f_bus_out, dir + 8'((c - 1) / 4));
                if (r == 2) chk("fast data bus", f_bus_out, (c > 4) ? d1 : d0);
            end else if (c == 9) begin
                ev = 7'b1111110;
            end else begin
                ev = 7'b1111000;
            end
            chk("fast {CS,AD,RD,WR,final,ocupado,tomado}",
                {f_CS, f_AD, f_RD, f_WR, f_finalizado, f_ocupado, f_dato_tomado}, 32'(ev));
            if (f_dato_tomado) f_dato = d1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
